diffusion_addkey_serial: RTL and testbench

Parametrised, column-serial diffusion-plus-key-addition engine for the Blink datapath. It generalises the fixed 64-bit combinational MixColumns/AddKey layer in three ways: state width and cell width are parameters, the number of columns processed per clock is a parameter, and an inverse (decryption) mode is added. One state/key pair is accepted per valid/ready handshake and one result is returned per handshake. It sits between the S-box layer and the round register in area-optimised round cores.

---
 rtl/diffusion_addkey_serial_if.sv | 22 ++
 rtl/diffusion_addkey_serial.sv | 129 ++++++++++++
 tb/tb_diffusion_addkey_serial.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/diffusion_addkey_serial_if.sv
// Handshake bundle for the column-serial diffusion/key-add engine.
// Input side and output side are each a valid/ready pair; N sets the word width.
interface diffusion_addkey_serial_if #(parameter int N = 64);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N-1:0] in_key;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, in_key, in_inv, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, in_inv, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/diffusion_addkey_serial.sv
// Column-serial diffusion + key addition with forward/inverse modes.
// P column lanes rewrite the working register in place, B = COLS/P cycles per word.
module diffusion_col #(
  parameter int M = 4
) (
  input  logic [3:0][M-1:0] x,
  input  logic [3:0][M-1:0] k,
  input  logic              inv,
  output logic [3:0][M-1:0] y
);
  logic [3:0][M-1:0] t;
  logic [M-1:0]      tsum;

  // Forward sums the plain cells; inverse sums the key-added cells.
  always_comb begin
    for (int r = 0; r < 4; r++) t[r] = inv ? (x[r] ^ k[r]) : x[r];
    tsum = t[0] ^ t[1] ^ t[2] ^ t[3];
    for (int r = 0; r < 4; r++) y[r] = inv ? (tsum ^ t[r]) : (tsum ^ x[r] ^ k[r]);
  end
endmodule

module diffusion_addkey_serial #(
  parameter int N = 64,
  parameter int M = 4,
  parameter int P = 1
) (
  input logic                      clk,
  input logic                      rst,
  diffusion_addkey_serial_if.slave bus
);
  localparam int COLS = N / (4 * M);
  localparam int B    = COLS / P;
  localparam int CW   = (B > 1) ? $clog2(B) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(B - 1);

  generate
    if ((N % (4 * M)) != 0 || (COLS % P) != 0) begin : g_bad_params
      $error("diffusion_addkey_serial: N must be a multiple of 4*M and COLS a multiple of P");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  w_q, w_d;
  logic [N-1:0]  k_q, k_d;
  logic          inv_q, inv_d;
  logic          rdy, load;

  logic [P-1:0][3:0][M-1:0] lx, lk, ly;

  // Gather the P columns selected by the counter into the lanes.
  always_comb begin
    lx = '0;
    lk = '0;
    for (int p = 0; p < P; p++) begin
      for (int r = 0; r < 4; r++) begin
        lx[p][r] = w_q[M*(r*COLS + int'(cnt_q)*P + p) +: M];
        lk[p][r] = k_q[M*(r*COLS + int'(cnt_q)*P + p) +: M];
      end
    end
  end

  generate
    for (genvar g = 0; g < P; g++) begin : g_lane
      diffusion_col #(.M(M)) u_col (
        .x  (lx[g]),
        .k  (lk[g]),
        .inv(inv_q),
        .y  (ly[g])
      );
    end
  endgenerate

  assign rdy  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign load = bus.in_valid && rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    k_d     = k_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
        for (int p = 0; p < P; p++)
          for (int r = 0; r < 4; r++)
            w_d[M*(r*COLS + int'(cnt_q)*P + p) +: M] = ly[p][r];
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Acceptance overrides the DONE->IDLE exit for back-to-back words.
    if (load) begin
      w_d     = bus.in_data;
      k_d     = bus.in_key;
      inv_d   = bus.in_inv;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      k_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      k_q     <= k_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = w_q;
endmodule

// File: tb/tb_diffusion_addkey_serial.sv
// Directed-vector bench for diffusion_addkey_serial: 64/4/P=1 and 128/8/P=2 instances.
module tb_diffusion_addkey_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  diffusion_addkey_serial_if #(.N(64))  ia();
  diffusion_addkey_serial_if #(.N(128)) ib();

  diffusion_addkey_serial #(.N(64),  .M(4), .P(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  diffusion_addkey_serial #(.N(128), .M(8), .P(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    logic [127:0] x;
    logic [127:0] k;
    bit           inv;
    logic [127:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: straight per-column evaluation of the diffusion equations.
  function automatic logic [127:0] model(input logic [127:0] x, input logic [127:0] k,
                                         input bit inv, input int n, input int m);
    int cols;
    logic [127:0] y, mask;
    logic [7:0] xc [4];
    logic [7:0] kc [4];
    logic [7:0] tt;
    cols = n / (4 * m);
    y    = '0;
    mask = (128'(1) << m) - 128'(1);
    for (int c = 0; c < cols; c++) begin
      tt = '0;
      for (int r = 0; r < 4; r++) begin
        xc[r] = 8'((x >> (m * (r * cols + c))) & mask);
        kc[r] = 8'((k >> (m * (r * cols + c))) & mask);
        tt    = tt ^ (inv ? (xc[r] ^ kc[r]) : xc[r]);
      end
      for (int r = 0; r < 4; r++)
        y = y | (128'(tt ^ xc[r] ^ kc[r]) << (m * (r * cols + c)));
    end
    return y;
  endfunction

  function automatic logic ov(input bit big);
    return big ? ib.out_valid : ia.out_valid;
  endfunction
  function automatic logic ir(input bit big);
    return big ? ib.in_ready : ia.in_ready;
  endfunction
  function automatic logic [127:0] od(input bit big);
    return big ? ib.out_data : 128'(ia.out_data);
  endfunction

  task automatic drive(input bit big, input bit v, input logic [127:0] x,
                       input logic [127:0] k, input bit inv);
    if (big) begin
      ib.in_valid = v; ib.in_data = x; ib.in_key = k; ib.in_inv = inv;
    end else begin
      ia.in_valid = v; ia.in_data = x[63:0]; ia.in_key = k[63:0]; ia.in_inv = inv;
    end
  endtask

  // One word through an idle DUT with out_ready=1; inputs are scrambled after acceptance.
  task automatic xfer(input bit big, input logic [127:0] x, input logic [127:0] k,
                      input bit inv, output logic [127:0] res, output int lat);
    drive(big, 1'b1, x, k, inv);
    @(posedge clk); #1;
    drive(big, 1'b0, ~x, ~k, ~inv);
    lat = 0;
    while (!ov(big) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od(big);
    @(posedge clk); #1;
  endtask

  vec_t va[7];
  vec_t vb[5];

  initial begin
    logic [127:0] res, fw, held, x, k;
    int lat, na, nr, cyc;
    int acc[4];
    logic [63:0] bx[4];
    logic [63:0] bk[4];
    bit ok, seen;

    va[0] = '{128'h1, 128'h0, 1'b0, 128'h0001000100010000};
    va[1] = '{128'h0, 128'h0123456789ABCDEF, 1'b0, 128'h0123456789ABCDEF};
    va[2] = '{128'hFFFFFFFFFFFFFFFF, 128'h0, 1'b0, 128'hFFFFFFFFFFFFFFFF};
    va[3] = '{128'h0, 128'h1, 1'b1, 128'h0001000100010000};
    va[4] = '{128'h0001000100010000, 128'h0, 1'b1, 128'h1};
    va[5] = '{128'h1, 128'h1, 1'b0, 128'h0001000100010001};
    va[6] = '{128'h1, 128'h1, 1'b1, 128'h0};

    vb[0] = '{128'h1, 128'h0, 1'b0, 128'h00000001_00000001_00000001_00000000};
    vb[1] = '{128'h0, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0,
              128'h0123456789ABCDEF_FEDCBA9876543210};
    vb[2] = '{{128{1'b1}}, 128'h0, 1'b0, {128{1'b1}}};
    vb[3] = '{128'h0, 128'h1, 1'b1, 128'h00000001_00000001_00000001_00000000};
    vb[4] = '{128'h100, 128'h0, 1'b0, 128'h00000100_00000100_00000100_00000000};

    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;

    // Reset state, sampled while rst is still asserted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_in_ready",  128'(ir(0)), 128'(1));
    chk("rst_a_out_valid", 128'(ov(0)), 128'(0));
    chk("rst_a_out_data",  od(0), 128'(0));
    chk("rst_b_in_ready",  128'(ir(1)), 128'(1));
    chk("rst_b_out_valid", 128'(ov(1)), 128'(0));
    chk("rst_b_out_data",  od(1), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (va[i]) begin
      xfer(1'b0, va[i].x, va[i].k, va[i].inv, res, lat);
      chk($sformatf("vec_a%0d_data", i), res, va[i].exp);
      chk($sformatf("vec_a%0d_latency", i), 128'(lat), 128'(4));
    end
    foreach (vb[i]) begin
      xfer(1'b1, vb[i].x, vb[i].k, vb[i].inv, res, lat);
      chk($sformatf("vec_b%0d_data", i), res, vb[i].exp);
      chk($sformatf("vec_b%0d_latency", i), 128'(lat), 128'(2));
    end

    // Random round trips on both instances.
    for (int i = 0; i < 1000; i++) begin
      x = 128'({$urandom, $urandom});
      k = 128'({$urandom, $urandom});
      xfer(1'b0, x, k, 1'b0, fw, lat);
      chk("rand_a_fwd", fw, model(x, k, 1'b0, 64, 4));
      xfer(1'b0, fw, k, 1'b1, res, lat);
      chk("rand_a_roundtrip", res, x);
    end
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      xfer(1'b1, x, k, 1'b0, fw, lat);
      chk("rand_b_fwd", fw, model(x, k, 1'b0, 128, 8));
      xfer(1'b1, fw, k, 1'b1, res, lat);
      chk("rand_b_roundtrip", res, x);
    end

    // Back-to-back with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      bx[i] = {$urandom, $urandom};
      bk[i] = {$urandom, $urandom};
    end
    na = 0; nr = 0; cyc = 0;
    while ((na < 4 || nr < 4) && cyc < 100) begin
      if (na < 4) drive(1'b0, 1'b1, 128'(bx[na]), 128'(bk[na]), 1'b0);
      else        drive(1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      if (ia.out_valid && ia.out_ready) begin
        chk($sformatf("b2b_result%0d", nr), od(0), model(128'(bx[nr]), 128'(bk[nr]), 1'b0, 64, 4));
        nr++;
      end
      if (ia.in_valid && ia.in_ready) begin
        acc[na] = cyc;
        na++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("b2b_results_count", 128'(nr), 128'(4));
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_interval%0d", i), 128'(acc[i] - acc[i-1]), 128'(5));
    @(posedge clk); #1;

    // Output stall: data held, no acceptance while out_ready=0.
    x = 128'h0123456789ABCDEF;
    k = 128'h0F1E2D3C4B5A6978;
    ia.out_ready = 1'b0;
    drive(1'b0, 1'b1, x, k, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 128'hDEADBEEF, 128'h5, 1'b1);
    lat = 0;
    while (!ov(0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    held = od(0);
    chk("stall_result", held, model(x, k, 1'b0, 64, 4));
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (od(0) !== held || ir(0) !== 1'b0 || ov(0) !== 1'b1) ok = 1'b0;
    end
    chk("stall_hold", 128'(ok), 128'(1));
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    ia.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_idle", 128'({ir(0), ov(0)}), 128'(2'b10));

    // Reset during the second BUSY cycle aborts the word.
    drive(1'b0, 1'b1, 128'h1, 128'h0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready",  128'(ir(0)), 128'(1));
    chk("abort_out_valid", 128'(ov(0)), 128'(0));
    chk("abort_out_data",  od(0), 128'(0));
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov(0)) seen = 1'b1;
    end
    chk("abort_never_output", 128'(seen), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
